float_acc16: RTL
================

FLOAT_ACC16 -- requirements
Module: float_acc16

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, giving the width of the term counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-006 SHALL have port in_data, input, 16 bits: FP16 term (sign[15], exponent[14:10], mantissa[9:0]).
REQ-007 SHALL have port in_last, input, 1 bit: the current term ends the group.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is held on the outputs.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port out_sum, output, 16 bits: the FP16 accumulated sum.
REQ-011 SHALL have port out_count, output, COUNT_W bits: the number of terms accepted in the group.
REQ-012 SHALL have port out_ovf, output, 1 bit: the term count saturated in the group.

Function
REQ-013 SHALL implement states IDLE, ACCUM and HOLD.
- in_ready=1 in IDLE and ACCUM.
- in_ready=0 in HOLD.
REQ-014 SHALL perform a transfer when in_valid&&in_ready, one term per cycle, with no bubbles.
REQ-015 SHALL, on a transfer, update acc <= fpadd(base, in_data).
- base=0x0000 in IDLE.
- base=acc in ACCUM.
REQ-016 SHALL, on a transfer, increment count, saturating at 2^COUNT_W-1.
- An increment attempted at saturation sets the sticky ovf flag.
REQ-017 SHALL apply these transitions on a transfer:
- With in_last=0: go to ACCUM.
- With in_last=1: go to HOLD.
- In both cases, acc and count include the current term.
REQ-018 SHALL, in HOLD, drive out_valid=1 and out_sum/out_count/out_ovf from the registers.
- out_valid rises exactly 1 cycle after the in_last transfer.
- Outputs stay stable until out_ready=1.
REQ-019 SHALL, in HOLD with out_ready=1, clear acc, count and ovf and go to IDLE.
- A new term is accepted no earlier than the following cycle.
REQ-020 SHALL drive out_valid=0 in IDLE and ACCUM.
- out_sum, out_count and out_ovf show the live registers there; the consumer ignores them.
REQ-021 SHALL ignore in_data and in_last when no transfer occurs.
REQ-022 SHALL compute fpadd(a,b) combinationally, with no rounding and no subnormals:
- If a==0x0000, return b.
- Else if b==0x0000, return a.
- 0x8000 is an ordinary nonzero operand.
REQ-023 SHALL, in fpadd, return 0x0000 when a[14:0]==b[14:0] and the signs differ.
REQ-024 SHALL, in fpadd, align operands as follows:
- Fractions are {1,mantissa}, 11 bits.
- The smaller-exponent fraction is right-shifted by the exponent difference, truncating; a shift of 11 or more gives 0.
- The result exponent is the larger exponent, held in a 6-bit signed intermediate.
REQ-025 SHALL, in fpadd with equal signs:
- Use a 12-bit fraction sum.
- On carry, shift right 1 (truncate) and increment the exponent.
- Take the sign from the operands.
REQ-026 SHALL, in fpadd with different signs:
- Compute positive-minus-negative fraction in 12 bits; the borrow bit is the result sign.
- If borrow, two's-complement-negate the 11-bit fraction.
- Normalize by left-shifting to the first 1 in bits [10:0], decrementing the exponent by the shift.
REQ-027 SHALL, in fpadd, return 0x0000 when intermediate exponent bit 5 is set (underflow, or overflow past 31).
- Otherwise return {sign, exponent[4:0], fraction[9:0]}.

Reset
REQ-028 SHALL, while reset=1 at a clock edge:
- Force state=IDLE.
- Clear acc=0x0000, count=0 and ovf=0.
- Drive out_valid=0 and in_ready=1 on the next cycle.
REQ-029 SHALL give reset priority over any transfer or out_ready in the same cycle, including mid-group and in HOLD.
- Any partial group is discarded.

Verification
REQ-030 SHALL cover two-term accumulation: 0x3C00 then 0x4000 with last -> out_sum=0x4200, out_count=2, out_valid 1 cycle after last.
REQ-031 SHALL cover mixed signs: 0xBC00 then 0x3800 with last -> out_sum=0xB800; also 0x4000 then 0xC000 with last -> out_sum=0x0000.
REQ-032 SHALL cover a single term: 0x4200 with last in IDLE -> out_sum=0x4200, out_count=1.
REQ-033 SHALL cover backpressure: out_ready low 3 cycles in HOLD with in_valid high -> in_ready=0 and outputs stable; out_ready=1 -> IDLE next cycle and the next term is accepted.
REQ-034 SHALL cover reset mid-group: after 0x3C00, 0x3C00, assert reset 1 cycle, then 0x3800 with last -> out_sum=0x3800, out_count=1.
REQ-035 SHALL cover count saturation: with COUNT_W=2, five 0x0000 terms with last -> out_count=3, out_ovf=1, out_sum=0x0000.

Source files
------------

// File: rtl/float_acc16.sv
// Streaming FP16 accumulator: sums a group of terms closed by in_last and holds the
// result until the consumer takes it. The adder truncates and has no subnormals.
module float_acc16 #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t               state_r, state_s;
  logic [15:0]          acc_r, acc_s;
  logic [COUNT_W-1:0]   count_r, count_s;
  logic                 ovf_r, ovf_s;
  logic                 out_valid_r;
  logic                 in_ready_r;
  logic                 xfer_s;
  logic [15:0]          base_s;

  // Truncating FP16 add; zero operands pass the other through, exponent bit 5 flags out of range.
  function automatic logic [15:0] fpadd(input logic [15:0] a, input logic [15:0] b);
    logic        big_is_a;
    logic [4:0]  e_big;
    logic [4:0]  e_small;
    logic [4:0]  e_diff;
    logic [10:0] f_big;
    logic [10:0] f_small;
    logic [10:0] f_a;
    logic [10:0] f_b;
    logic [10:0] frac;
    logic [11:0] wide;
    logic [5:0]  exp;
    logic        sign;
    logic [3:0]  lz;
    logic        found;
    logic [15:0] res;
    res      = 16'h0000;
    big_is_a = 1'b0;
    e_big    = 5'd0;
    e_small  = 5'd0;
    e_diff   = 5'd0;
    f_big    = 11'd0;
    f_small  = 11'd0;
    f_a      = 11'd0;
    f_b      = 11'd0;
    frac     = 11'd0;
    wide     = 12'd0;
    exp      = 6'd0;
    sign     = 1'b0;
    lz       = 4'd0;
    found    = 1'b0;
    if (a == 16'h0000) begin
      res = b;
    end else if (b == 16'h0000) begin
      res = a;
    end else if ((a[14:0] == b[14:0]) && (a[15] != b[15])) begin
      res = 16'h0000;
    end else begin
      big_is_a = (a[14:10] >= b[14:10]);
      e_big    = big_is_a ? a[14:10] : b[14:10];
      e_small  = big_is_a ? b[14:10] : a[14:10];
      f_big    = big_is_a ? {1'b1, a[9:0]} : {1'b1, b[9:0]};
      f_small  = big_is_a ? {1'b1, b[9:0]} : {1'b1, a[9:0]};
      e_diff   = e_big - e_small;
      f_small  = (e_diff >= 5'd11) ? 11'd0 : (f_small >> e_diff);
      f_a      = big_is_a ? f_big : f_small;
      f_b      = big_is_a ? f_small : f_big;
      exp      = {1'b0, e_big};
      if (a[15] == b[15]) begin
        wide = {1'b0, f_a} + {1'b0, f_b};
        sign = a[15];
        if (wide[11]) begin
          frac = wide[11:1];
          exp  = exp + 6'd1;
        end else begin
          frac = wide[10:0];
        end
      end else begin
        // Positive minus negative; the borrow out becomes the result sign.
        wide = a[15] ? ({1'b0, f_b} - {1'b0, f_a}) : ({1'b0, f_a} - {1'b0, f_b});
        sign = wide[11];
        frac = wide[11] ? (11'd0 - wide[10:0]) : wide[10:0];
        for (int i = 10; i >= 0; i--) begin
          if (found) begin
            found = 1'b1;
          end else if (frac[i]) begin
            found = 1'b1;
          end else begin
            lz = lz + 4'd1;
          end
        end
        frac = frac << lz;
        exp  = exp - {2'b00, lz};
      end
      if (exp[5] || (frac == 11'd0)) begin
        res = 16'h0000;
      end else begin
        res = {sign, exp[4:0], frac[9:0]};
      end
    end
    return res;
  endfunction

  // Next-state, accumulator and counter update.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    count_s = count_r;
    ovf_s   = ovf_r;
    xfer_s  = in_valid && in_ready_r;
    base_s  = (state_r == IDLE) ? 16'h0000 : acc_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (xfer_s) begin
          acc_s = fpadd(base_s, in_data);
          if (count_r == COUNT_MAX) begin
            ovf_s = 1'b1;
          end else begin
            count_s = count_r + COUNT_ONE;
          end
          state_s = in_last ? HOLD : ACCUM;
        end else begin
          state_s = state_r;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_s   = 16'h0000;
          count_s = {COUNT_W{1'b0}};
          ovf_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        acc_s   = 16'h0000;
        count_s = {COUNT_W{1'b0}};
        ovf_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= 16'h0000;
      count_r     <= {COUNT_W{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      count_r     <= count_s;
      ovf_r       <= ovf_s;
      out_valid_r <= (state_s == HOLD);
      in_ready_r  <= (state_s != HOLD);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_count = count_r;
  assign out_ovf   = ovf_r;

endmodule
